// File: rtl/ps2_scan_rx.sv
// Host-side PS/2 receiver: pin synchronizers, 11-bit frame decoder with
// parity/stop/timeout checks, E0/F0 prefix folding and a small code FIFO.
module ps2_scan_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code_out,
   output logic       code_ext,
   output logic       code_brk,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       frame_err,
   output logic       overflow
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [2:0]       bitcnt;
   logic [7:0]       shreg;
   logic             par_bit;
   logic [CNT_W-1:0] tcnt;
   logic             ext;
   logic             brk;

   logic clk_p0, clk_p1, clk_p2;
   logic dat_p0, dat_p1;

   logic [9:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [9:0]  head;

   logic fall, stop_fall, good, push, full, empty, pop, wr_en;

   // Two-flop synchronizers on both pins plus a delayed copy of the clock for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_p0 <= 1'b1;
         clk_p1 <= 1'b1;
         clk_p2 <= 1'b1;
         dat_p0 <= 1'b1;
         dat_p1 <= 1'b1;
      end else begin
         clk_p0 <= ps2_clk;
         clk_p1 <= clk_p0;
         clk_p2 <= clk_p1;
         dat_p0 <= ps2_data;
         dat_p1 <= dat_p0;
      end
   end

   assign fall      = clk_p2 & ~clk_p1;
   assign stop_fall = fall && (state == STOP);
   // odd parity over data+parity, and the stop bit must be high
   assign good      = stop_fall && dat_p1 && (^{shreg, par_bit});
   assign push      = good && (shreg != 8'hE0) && (shreg != 8'hF0);

   // Frame decoder: start/data/parity/stop sequencing, timeout and prefix flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bitcnt    <= 3'd0;
         shreg     <= 8'h00;
         par_bit   <= 1'b0;
         tcnt      <= '0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (state == IDLE) begin
            tcnt <= '0;
            if (fall && !dat_p1) begin
               state  <= DATA;
               bitcnt <= 3'd0;
            end
         end else if (fall) begin
            tcnt <= '0;
            case (state)
               DATA: begin
                  shreg <= {dat_p1, shreg[7:1]};
                  if (bitcnt == 3'd7) state <= PARITY;
                  else                bitcnt <= bitcnt + 3'd1;
               end
               PARITY: begin
                  par_bit <= dat_p1;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (good) begin
                     if (shreg == 8'hE0)      ext <= 1'b1;
                     else if (shreg == 8'hF0) brk <= 1'b1;
                     else begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                     end
                  end else begin
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                     frame_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (tcnt == TO_LAST) begin
            // keyboard stopped clocking mid-frame: abandon it
            state     <= IDLE;
            tcnt      <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            frame_err <= 1'b1;
         end else begin
            tcnt <= tcnt + CNT_W'(1);
         end
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && code_ready;
   // a simultaneous pop frees the slot being written when full
   assign wr_en = push && (!full || pop);

   // FIFO pointers and the overflow pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full && !pop;
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // FIFO storage; contents are only observed through the valid-gated head
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {ext, brk, shreg};
   end

   assign head       = mem[rd_ptr[AW-1:0]];
   assign code_valid = !empty;
   assign code_out   = code_valid ? head[7:0] : 8'h00;
   assign code_brk   = code_valid ? head[8]   : 1'b0;
   assign code_ext   = code_valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: bit-banged PS/2 frames, a queue of
// expected codes popped whenever the DUT hands a code over, pulse counters.
`timescale 1ns/1ps
module tb_ps2_scan_rx;

   localparam int TO    = 300;
   localparam int DEPTH = 4;
   localparam int HALF  = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       code_ready = 1'b0;
   logic [7:0] code_out;
   logic       code_ext, code_brk, code_valid, frame_err, overflow;

   int checks = 0;
   int errors = 0;
   int ferr_cnt = 0;
   int ovf_cnt = 0;
   int cyc = 0;
   int stop_cyc = 0;
   int rise_cyc = -1;
   logic prev_valid = 1'b0;

   logic [9:0] exp_q[$];
   logic [9:0] mon_e;
   logic       m_ext = 1'b0;
   logic       m_brk = 1'b0;

   ps2_scan_rx #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .code_out(code_out), .code_ext(code_ext), .code_brk(code_brk),
      .code_valid(code_valid), .code_ready(code_ready),
      .frame_err(frame_err), .overflow(overflow));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: pulse counters and scoreboard comparison on every handshake
   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
      if (code_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = code_valid;
      if (code_valid && code_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got ext=%0b brk=%0b code=%02h, expected no entry",
                     code_ext, code_brk, code_out);
         end else begin
            mon_e = exp_q.pop_front();
            if ({code_ext, code_brk, code_out} !== mon_e) begin
               errors++;
               $display("FAIL pop_data: got ext=%0b brk=%0b code=%02h, expected ext=%0b brk=%0b code=%02h",
                        code_ext, code_brk, code_out, mon_e[9], mon_e[8], mon_e[7:0]);
            end
         end
      end
   end

   // send nbits of a frame (11 = complete); model predicts the resulting entry
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                             input bit store, input bit pop_at_stop);
      logic [10:0] f;
      logic par;
      par = ~(^b);
      if (bad_par) par = ~par;
      f = {1'b1, par, b, 1'b0};
      if (nbits == 11 && !bad_par) begin
         if (b == 8'hE0)      m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else begin
            if (store) exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end else begin
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk); #1 ps2_data = f[i];
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         for (int k = 0; k < HALF; k++) begin
            @(posedge clk); #1;
            if (pop_at_stop && i == 10 && k == 1)      code_ready = 1'b1;
            else if (pop_at_stop && i == 10 && k == 2) code_ready = 1'b0;
         end
         ps2_clk = 1'b1;
      end
      @(posedge clk); #1 ps2_data = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      @(posedge clk); #1 code_ready = 1'b1;
      @(posedge clk); #1 code_ready = 1'b0;
   endtask

   task automatic drain();
      @(posedge clk); #1 code_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      #1 code_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({code_out, code_ext, code_brk, code_valid, frame_err, overflow} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %013b, expected all zero",
                  {code_out, code_ext, code_brk, code_valid, frame_err, overflow});
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (code_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_valid: got %0b, expected 0", code_valid);
      end
   endtask

   task automatic test_single();
      code_ready = 1'b0;
      rise_cyc = -1;
      send_frame(8'h1D, 0, 11, 1, 0);
      checks++;
      if (rise_cyc - stop_cyc < 3 || rise_cyc - stop_cyc > 4) begin
         errors++;
         $display("FAIL single_latency: valid rose %0d clk after stop edge, expected 3..4",
                  rise_cyc - stop_cyc);
      end
      checks++;
      if ({code_valid, code_ext, code_brk, code_out} !== {3'b100, 8'h1D}) begin
         errors++;
         $display("FAIL single_head: got v=%0b e=%0b b=%0b code=%02h, expected v=1 e=0 b=0 code=1d",
                  code_valid, code_ext, code_brk, code_out);
      end
      pop_one();
      checks++;
      if (code_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_valid_after_pop: got %0b, expected 0", code_valid);
      end
   endtask

   task automatic test_ext_break();
      code_ready = 1'b0;
      send_frame(8'hE0, 0, 11, 1, 0);
      send_frame(8'hF0, 0, 11, 1, 0);
      send_frame(8'h75, 0, 11, 1, 0);
      checks++;
      if ({code_valid, code_ext, code_brk, code_out} !== {3'b111, 8'h75}) begin
         errors++;
         $display("FAIL extbrk_head: got v=%0b e=%0b b=%0b code=%02h, expected v=1 e=1 b=1 code=75",
                  code_valid, code_ext, code_brk, code_out);
      end
      pop_one();
      checks++;
      if (code_valid !== 1'b0) begin
         errors++;
         $display("FAIL extbrk_single_entry: valid got %0b, expected 0", code_valid);
      end
      send_frame(8'h75, 0, 11, 1, 0);
      checks++;
      if ({code_valid, code_ext, code_brk, code_out} !== {3'b100, 8'h75}) begin
         errors++;
         $display("FAIL extbrk_flags_cleared: got v=%0b e=%0b b=%0b code=%02h, expected v=1 e=0 b=0 code=75",
                  code_valid, code_ext, code_brk, code_out);
      end
      pop_one();
   endtask

   task automatic test_parity();
      int e0;
      code_ready = 1'b0;
      e0 = ferr_cnt;
      send_frame(8'h1D, 1, 11, 1, 0);
      checks++;
      if (ferr_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL parity_err_pulse: got %0d high cycles, expected 1", ferr_cnt - e0);
      end
      checks++;
      if (code_valid !== 1'b0) begin
         errors++;
         $display("FAIL parity_no_push: valid got %0b, expected 0", code_valid);
      end
      send_frame(8'hF0, 0, 11, 1, 0);
      send_frame(8'h1D, 0, 11, 1, 0);
      checks++;
      if ({code_valid, code_ext, code_brk, code_out} !== {3'b101, 8'h1D}) begin
         errors++;
         $display("FAIL parity_then_break: got v=%0b e=%0b b=%0b code=%02h, expected v=1 e=0 b=1 code=1d",
                  code_valid, code_ext, code_brk, code_out);
      end
      pop_one();
   endtask

   task automatic test_timeout();
      int e0;
      code_ready = 1'b0;
      e0 = ferr_cnt;
      send_frame(8'hE0, 0, 11, 1, 0);
      send_frame(8'h55, 0, 5, 1, 0);
      checks++;
      if (ferr_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL timeout_early: got %0d error cycles, expected 0", ferr_cnt - e0);
      end
      repeat (TO + 20) @(posedge clk);
      #1;
      checks++;
      if (ferr_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL timeout_pulse: got %0d error cycles, expected 1", ferr_cnt - e0);
      end
      send_frame(8'h1C, 0, 11, 1, 0);
      checks++;
      if ({code_valid, code_ext, code_brk, code_out} !== {3'b100, 8'h1C}) begin
         errors++;
         $display("FAIL timeout_recover: got v=%0b e=%0b b=%0b code=%02h, expected v=1 e=0 b=0 code=1c",
                  code_valid, code_ext, code_brk, code_out);
      end
      pop_one();
   endtask

   task automatic test_overflow();
      int o0;
      code_ready = 1'b0;
      o0 = ovf_cnt;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 11, 1, 0);
      checks++;
      if (ovf_cnt - o0 !== 0) begin
         errors++;
         $display("FAIL ovf_fill: got %0d overflow cycles, expected 0", ovf_cnt - o0);
      end
      send_frame(8'h05, 0, 11, 0, 0);
      checks++;
      if (ovf_cnt - o0 !== 1) begin
         errors++;
         $display("FAIL ovf_pulse: got %0d overflow cycles, expected 1", ovf_cnt - o0);
      end
      checks++;
      if (code_out !== 8'h01) begin
         errors++;
         $display("FAIL ovf_head_kept: got %02h, expected 01", code_out);
      end
      drain();
      checks++;
      if (exp_q.size() != 0 || code_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drain: got %0d pending, valid=%0b, expected 0 pending, valid=0",
                  exp_q.size(), code_valid);
      end
      o0 = ovf_cnt;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 11, 1, 0);
      send_frame(8'h05, 0, 11, 1, 1);
      checks++;
      if (ovf_cnt - o0 !== 0) begin
         errors++;
         $display("FAIL ovf_pushpop: got %0d overflow cycles, expected 0", ovf_cnt - o0);
      end
      checks++;
      if (code_out !== 8'h02) begin
         errors++;
         $display("FAIL ovf_pushpop_head: got %02h, expected 02", code_out);
      end
      drain();
      checks++;
      if (exp_q.size() != 0 || code_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pushpop_drain: got %0d pending, valid=%0b, expected 0 pending, valid=0",
                  exp_q.size(), code_valid);
      end
   endtask

   task automatic test_back_to_back();
      code_ready = 1'b0;
      send_frame(8'h11, 0, 11, 1, 0);
      send_frame(8'h22, 0, 11, 1, 0);
      send_frame(8'h33, 0, 11, 1, 0);
      @(posedge clk); #1 code_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (code_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got valid=%0b pending=%0d after 3 clk, expected valid=0 pending=0",
                  code_valid, exp_q.size());
      end
      code_ready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      code_ready = 1'b0;
      send_frame(8'h31, 0, 11, 1, 0);
      send_frame(8'h32, 0, 11, 1, 0);
      send_frame(8'h44, 0, 3, 1, 0);
      checks++;
      if (code_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_queued: valid got %0b, expected 1", code_valid);
      end
      @(posedge clk); #3 reset = 1'b0;
      #1;
      checks++;
      if ({code_out, code_ext, code_brk, code_valid, frame_err, overflow} !== 13'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got %013b, expected all zero",
                  {code_out, code_ext, code_brk, code_valid, frame_err, overflow});
      end
      exp_q.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send_frame(8'h29, 0, 11, 1, 0);
      checks++;
      if ({code_valid, code_ext, code_brk, code_out} !== {3'b100, 8'h29}) begin
         errors++;
         $display("FAIL midreset_recover: got v=%0b e=%0b b=%0b code=%02h, expected v=1 e=0 b=0 code=29",
                  code_valid, code_ext, code_brk, code_out);
      end
      pop_one();
      checks++;
      if (code_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_final: got valid=%0b pending=%0d, expected valid=0 pending=0",
                  code_valid, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ext_break();
      test_parity();
      test_timeout();
      test_overflow();
      test_back_to_back();
      test_reset_midframe();
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Host-side PS/2 receive controller that sequences the keyboard datapath on the system clock. It synchronizes the raw PS/2 clock and data lines and frames 11-bit packets with parity, stop-bit and timeout checks. It folds the E0 (extended) and F0 (break) prefixes into flags on the following scancode and buffers completed codes in a small FIFO behind a valid/ready handshake. The key-state and hold-counter logic consumes its output without sampling on the PS/2 clock edge directly.

## Interface
- TIMEOUT_CYCLES, 50000: system clocks allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- FIFO_DEPTH, 4: decoded-code entries; power of two, ≥2.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high.
- ps2_data  in  1  raw PS/2 data pin, asynchronous, idle high.
- code_out  out  8  scancode at FIFO head.
- code_ext  out  1  head code was preceded by E0.
- code_brk  out  1  head code was preceded by F0 (key release).
- code_valid  out  1  FIFO non-empty; head fields valid.
- code_ready  in  1  consumer accepts head this cycle.
- frame_err  out  1  one-cycle pulse: parity, stop or timeout failure.
- overflow  out  1  one-cycle pulse: completed code dropped, FIFO full.

## Operation
- Sync: each pin passes through two flops reset to 1. A third flop holds the previous synced clock. A falling edge `fall` is flagged when the previous value is 1 and the current value is 0. Synced data is sampled in the `fall` cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on `fall`, except timeout.
  - IDLE: fall with data=0 goes to DATA with bitcnt=0. Fall with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: go to IDLE. The frame is good iff the 8 data bits plus the parity bit contain an odd number of ones and stop=1.
- Bad frame: byte discarded, ext/brk flags cleared, frame_err pulses in the cycle after the STOP fall.
- Timeout: the counter clears on every `fall` and in IDLE. In DATA, PARITY or STOP, if the counter reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, the partial byte is discarded, flags are cleared and frame_err pulses.
- Prefix handling on a good byte:
  - 0xE0 sets ext; nothing is pushed.
  - 0xF0 sets brk; nothing is pushed.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - E0 followed by F0 leaves both flags set.
- FIFO:
  - code_valid = not empty. The head is presented continuously.
  - Pop when code_valid && code_ready.
  - Push when full and no pop in the same cycle: new entry dropped, overflow pulses, flags still cleared.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: not possible, since valid=0.
- Head fields are don't-care while code_valid=0. They are 0 out of reset.

## Timing
- Reset (asynchronous assert): FSM=IDLE; bitcnt, shift register, counter, ext, brk and FIFO pointers cleared; sync flops=1.
- Outputs during reset: code_out=0, code_ext=0, code_brk=0, code_valid=0, frame_err=0, overflow=0.
- Reset deasserted mid-frame: the partial frame is lost. The next start bit is accepted normally.
- Pin-to-`fall` latency: 2-3 clk.
- Push happens at the end of the STOP `fall` cycle. code_valid is high the following cycle when the FIFO was empty.
- frame_err and overflow are exactly one clk wide and registered.
- A pop takes effect on the clock edge. The next head is visible the cycle after the pop, with valid staying high if entries remain.
- The consumer may hold code_ready high permanently, giving one code per cycle drain.
- The counter is wide enough for TIMEOUT_CYCLES-1. It must not wrap at the parameter maximum.

## Test plan
- Single make code: send frame 0x1D (parity 1, stop 1) -> code_valid rises the cycle after the stop edge with code_out=0x1D, ext=0, brk=0; code_ready=1 -> valid falls next cycle.
- Extended break: frames E0, F0, 75 -> exactly one entry, code_out=0x75, ext=1, brk=1. A following frame 0x75 -> ext=0, brk=0.
- Parity error: frame 0x1D with parity 0 -> frame_err one-cycle pulse, no push. A following F0 then 1D -> brk=1 only.
- Timeout: stop clocking after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM back to IDLE. The next full frame 0x1C -> code_out=0x1C.
- Overflow with code_ready=0: send 5 codes 0x01..0x05 -> overflow pulses on the 5th. Pops then return 0x01..0x04 in order. Repeat with a pop coinciding with the 5th push -> no overflow, 0x05 retained.
- Async reset asserted mid-DATA with 2 entries queued -> code_valid=0 immediately and all outputs 0. After release, frame 0x29 -> code_out=0x29.
